// File: rtl/event_replay_driver.sv
// Replays timestamped input events into a generated RTLola monitor and captures
// every monitor result stream a fixed settle window after each drive.
module event_replay_driver #(
    parameter int NUM_IN        = 3,
    parameter int NUM_OUT       = 12,
    parameter int DATA_W        = 32,
    parameter int TS_W          = 32,
    parameter int HOLD_CYCLES   = 1,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      ev_valid,
    output logic                      ev_ready,
    input  logic [TS_W-1:0]           ev_ts,
    input  logic [NUM_IN*DATA_W-1:0]  ev_data,
    input  logic [NUM_IN-1:0]         ev_has,
    output logic                      mon_en,
    output logic [NUM_IN*DATA_W-1:0]  mon_x,
    output logic [NUM_IN-1:0]         mon_has,
    input  logic [NUM_OUT*DATA_W-1:0] mon_result,
    output logic                      snap_valid,
    input  logic                      snap_ready,
    output logic [TS_W-1:0]           snap_ts,
    output logic [NUM_IN-1:0]         snap_has,
    output logic [NUM_OUT*DATA_W-1:0] snap_result,
    output logic                      late_err,
    output logic [TS_W-1:0]           cycle_now,
    output logic [2:0]                dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_DRIVE  = 3'd2,
        S_SETTLE = 3'd3,
        S_EMIT   = 3'd4
    } state_t;

    // One shared counter serves both the hold and the settle phase.
    localparam int CNT_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t                      r_state;
    logic [CNT_W-1:0]            r_cnt;
    logic [TS_W-1:0]             r_cycle;
    logic [TS_W-1:0]             r_ts;
    logic [NUM_IN*DATA_W-1:0]    r_data;
    logic [NUM_IN-1:0]           r_has;
    logic [TS_W-1:0]             r_snap_ts;
    logic [NUM_IN-1:0]           r_snap_has;
    logic [NUM_OUT*DATA_W-1:0]   r_snap_result;
    logic                        r_late;

    state_t                      w_next_state;
    logic [CNT_W-1:0]            w_cnt_next;
    logic [TS_W-1:0]             w_cycle_next;
    logic                        w_accept;
    logic                        w_late;
    logic                        w_capture;

    // Handshakes: a transfer happens on a rising clk edge where valid && ready.
    // Both streams pause while en = 0 (ev_ready and snap_valid deassert), so no
    // transfer can slip past a frozen FSM; valid/ready never depend on each other
    // combinationally inside this block.
    always_comb begin
        ev_ready   = (r_state == S_IDLE) && en;
        snap_valid = (r_state == S_EMIT) && en;
    end

    always_comb begin
        w_cycle_next = (&r_cycle) ? r_cycle : r_cycle + TS_W'(1);
        w_accept     = ev_valid && ev_ready;
        w_late       = w_accept && (ev_ts < r_cycle);
    end

    // Next state is judged against the count the following cycle will show, so
    // DRIVE starts on the first cycle with cycle_now >= ts, and a late event
    // drives directly in the cycle after accept.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        if (en) begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_next = '0;
                    if (w_accept) begin
                        w_next_state = (w_cycle_next >= ev_ts) ? S_DRIVE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    w_cnt_next = '0;
                    if (w_cycle_next >= r_ts) begin
                        w_next_state = S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_next_state = S_SETTLE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        w_next_state = S_EMIT;
                        w_cnt_next   = '0;
                        w_capture    = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                S_EMIT: begin
                    if (snap_valid && snap_ready) begin
                        w_next_state = S_IDLE;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_cycle       <= '0;
            r_ts          <= '0;
            r_data        <= '0;
            r_has         <= '0;
            r_snap_ts     <= '0;
            r_snap_has    <= '0;
            r_snap_result <= '0;
            r_late        <= 1'b0;
        end else if (en) begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            r_cycle <= w_cycle_next;
            if (w_accept) begin
                r_ts   <= ev_ts;
                r_data <= ev_data;
                r_has  <= ev_has;
            end
            if (w_late) begin
                r_late <= 1'b1;
            end
            if (w_capture) begin
                r_snap_ts     <= r_ts;
                r_snap_has    <= r_has;
                r_snap_result <= mon_result;
            end
        end
    end

    always_comb begin
        mon_en      = en;
        mon_x       = (r_state == S_DRIVE) ? r_data : '0;
        mon_has     = (r_state == S_DRIVE) ? r_has : '0;
        snap_ts     = r_snap_ts;
        snap_has    = r_snap_has;
        snap_result = r_snap_result;
        late_err    = r_late;
        cycle_now   = r_cycle;
        dbg_state   = r_state;
    end

endmodule
